// File: rtl/id_stage_hazard_if.sv
// id_stage_hazard_if: bundles the IF/ID inputs, the writeback port and the
// registered ID/EX results of the decode stage. The master side drives the
// IF/ID and writeback signals; the slave side is the decode stage itself.
interface id_stage_hazard_if #(
   parameter int WIDTH       = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
);
   logic [WIDTH-1:0]       instruction_IFID;
   logic [WIDTH-1:0]       pc_IFID;
   logic [WIDTH-1:0]       pc_4_IFID;
   logic                   valid_IFID;
   logic                   flush;
   logic [WIDTH-1:0]       reg_wr_data_WBID;
   logic [REG_ADDR_W-1:0]  rd_WBID;
   logic                   reg_wr_en_WBID;

   logic                   stall_ID;
   logic                   valid_IDEX;
   logic [6:0]             op_IDEX;
   logic [6:0]             funct7_IDEX;
   logic [2:0]             funct3_IDEX;
   logic [WIDTH-1:0]       in1_IDEX;
   logic [WIDTH-1:0]       in2_IDEX;
   logic [WIDTH-1:0]       immediate_IDEX;
   logic [WIDTH-1:0]       pc_IDEX;
   logic [WIDTH-1:0]       pc_4_IDEX;
   logic [WIDTH-1:0]       rs2_data_IDEX;
   logic                   jump_branch_sel_IDEX;
   logic                   mem_wr_en_IDEX;
   logic                   reg_wr_en_IDEX;
   logic [1:0]             reg_wr_ctrl_IDEX;
   logic [REG_ADDR_W-1:0]  rd_IDEX;
   logic [REG_ADDR_W-1:0]  rs1_IDEX;
   logic [REG_ADDR_W-1:0]  rs2_IDEX;
   logic                   rs1_used_IDEX;
   logic                   rs2_used_IDEX;
   logic [STALL_CNT_W-1:0] stall_cnt;

   modport master (
      output instruction_IFID, pc_IFID, pc_4_IFID, valid_IFID, flush,
             reg_wr_data_WBID, rd_WBID, reg_wr_en_WBID,
      input  stall_ID, valid_IDEX, op_IDEX, funct7_IDEX, funct3_IDEX,
             in1_IDEX, in2_IDEX, immediate_IDEX, pc_IDEX, pc_4_IDEX,
             rs2_data_IDEX, jump_branch_sel_IDEX, mem_wr_en_IDEX,
             reg_wr_en_IDEX, reg_wr_ctrl_IDEX, rd_IDEX, rs1_IDEX, rs2_IDEX,
             rs1_used_IDEX, rs2_used_IDEX, stall_cnt
   );

   modport slave (
      input  instruction_IFID, pc_IFID, pc_4_IFID, valid_IFID, flush,
             reg_wr_data_WBID, rd_WBID, reg_wr_en_WBID,
      output stall_ID, valid_IDEX, op_IDEX, funct7_IDEX, funct3_IDEX,
             in1_IDEX, in2_IDEX, immediate_IDEX, pc_IDEX, pc_4_IDEX,
             rs2_data_IDEX, jump_branch_sel_IDEX, mem_wr_en_IDEX,
             reg_wr_en_IDEX, reg_wr_ctrl_IDEX, rd_IDEX, rs1_IDEX, rs2_IDEX,
             rs1_used_IDEX, rs2_used_IDEX, stall_cnt
   );
endinterface

// File: rtl/id_stage_hazard.sv
// id_stage_hazard: RV32I decode stage with internal register file, ID/EX
// register, load-use and writeback interlocks, flush and a saturating count
// of interlock stall cycles.
// Build option WB_BYPASS_EN: when defined, a register being written back in
// the same cycle is forwarded into the decode read; when undefined, such a
// read stalls decode for one cycle instead.
// Source fields of an opcode that does not read them are exported as index 0
// and read as zero, so LUI sees 0 on in1.
module id_stage_hazard #(
   parameter int         WIDTH       = 32,
   parameter int         REG_ADDR_W  = 5,
   parameter logic [6:0] NOP_OP      = 7'b0010011,
   parameter int         STALL_CNT_W = 16
) (
   input logic              clk,
   input logic              reset,
   id_stage_hazard_if.slave bus
);
   localparam int         NUM_REGS   = 2 ** REG_ADDR_W;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [1:0] WB_LOAD    = 2'b01;
   localparam logic [1:0] WB_PC4     = 2'b10;

   logic [WIDTH-1:0]       regs [NUM_REGS];
   logic [31:0]            instr;
   logic [6:0]             opcode;
   logic [REG_ADDR_W-1:0]  rs1_f, rs2_f, rd_f, rs1_idx, rs2_idx, rd_idx;
   logic                   uses_rs1, uses_rs2, writes_rd, pc_rs1_sel, imm_rs2_sel;
   logic                   is_jb, is_store;
   logic [1:0]             wr_ctrl;
   logic [WIDTH-1:0]       imm, rs1_data, rs2_data;
   logic                   rs1_used, rs2_used, wb_wr, load_use, wb_hz, hazard, bubble;
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   assign instr  = bus.instruction_IFID[31:0];
   assign opcode = instr[6:0];
   assign rs1_f  = REG_ADDR_W'(instr[19:15]);
   assign rs2_f  = REG_ADDR_W'(instr[24:20]);
   assign rd_f   = REG_ADDR_W'(instr[11:7]);

   // per-opcode control and immediate selection
   always_comb begin
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
      writes_rd   = 1'b0;
      pc_rs1_sel  = 1'b0;
      imm_rs2_sel = 1'b0;
      is_jb       = 1'b0;
      is_store    = 1'b0;
      wr_ctrl     = 2'b00;
      imm         = '0;
      case (opcode)
         OPC_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
         OPC_IMM:    begin
            uses_rs1 = 1'b1; imm_rs2_sel = 1'b1; writes_rd = 1'b1;
            imm = WIDTH'($signed(instr[31:20]));
         end
         OPC_LOAD:   begin
            uses_rs1 = 1'b1; imm_rs2_sel = 1'b1; writes_rd = 1'b1; wr_ctrl = WB_LOAD;
            imm = WIDTH'($signed(instr[31:20]));
         end
         OPC_STORE:  begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_rs2_sel = 1'b1; is_store = 1'b1;
            imm = WIDTH'($signed({instr[31:25], instr[11:7]}));
         end
         OPC_BRANCH: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_jb = 1'b1;
            imm = WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         end
         OPC_JALR:   begin
            uses_rs1 = 1'b1; imm_rs2_sel = 1'b1; writes_rd = 1'b1; is_jb = 1'b1; wr_ctrl = WB_PC4;
            imm = WIDTH'($signed(instr[31:20]));
         end
         OPC_JAL:    begin
            pc_rs1_sel = 1'b1; imm_rs2_sel = 1'b1; writes_rd = 1'b1; is_jb = 1'b1; wr_ctrl = WB_PC4;
            imm = WIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         end
         OPC_LUI:    begin
            imm_rs2_sel = 1'b1; writes_rd = 1'b1;
            imm = WIDTH'($signed({instr[31:12], 12'b0}));
         end
         OPC_AUIPC:  begin
            pc_rs1_sel = 1'b1; imm_rs2_sel = 1'b1; writes_rd = 1'b1;
            imm = WIDTH'($signed({instr[31:12], 12'b0}));
         end
         default: ;
      endcase
   end

   assign rs1_used = uses_rs1 & (rs1_f != '0);
   assign rs2_used = uses_rs2 & (rs2_f != '0);
   assign rs1_idx  = rs1_used ? rs1_f : '0;
   assign rs2_idx  = rs2_used ? rs2_f : '0;
   assign rd_idx   = writes_rd ? rd_f : '0;
   assign wb_wr    = bus.reg_wr_en_WBID & (bus.rd_WBID != '0);

`ifdef WB_BYPASS_EN
   assign rs1_data = (rs1_idx == '0) ? '0 :
                     (wb_wr && bus.rd_WBID == rs1_idx) ? bus.reg_wr_data_WBID : regs[rs1_idx];
   assign rs2_data = (rs2_idx == '0) ? '0 :
                     (wb_wr && bus.rd_WBID == rs2_idx) ? bus.reg_wr_data_WBID : regs[rs2_idx];
   assign wb_hz    = 1'b0;
`else
   assign rs1_data = (rs1_idx == '0) ? '0 : regs[rs1_idx];
   assign rs2_data = (rs2_idx == '0) ? '0 : regs[rs2_idx];
   assign wb_hz    = bus.valid_IFID & wb_wr &
                     ((rs1_used & (rs1_idx == bus.rd_WBID)) | (rs2_used & (rs2_idx == bus.rd_WBID)));
`endif

   assign load_use = bus.valid_IDEX & (bus.reg_wr_ctrl_IDEX == WB_LOAD) & (bus.rd_IDEX != '0) &
                     bus.valid_IFID &
                     ((rs1_used & (rs1_idx == bus.rd_IDEX)) | (rs2_used & (rs2_idx == bus.rd_IDEX)));
   assign hazard       = load_use | wb_hz;
   assign bubble       = bus.flush | hazard | ~bus.valid_IFID;
   assign bus.stall_ID = hazard & ~bus.flush & ~reset;
   assign bus.stall_cnt = stall_cnt_q;

   // register file: cleared on reset, written from the writeback port
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_wr) begin
         regs[bus.rd_WBID] <= bus.reg_wr_data_WBID;
      end
   end

   // ID/EX register: bubble on reset, flush, interlock or empty IF/ID
   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         bus.valid_IDEX           <= 1'b0;
         bus.op_IDEX              <= NOP_OP;
         bus.funct7_IDEX          <= '0;
         bus.funct3_IDEX          <= '0;
         bus.in1_IDEX             <= '0;
         bus.in2_IDEX             <= '0;
         bus.immediate_IDEX       <= '0;
         bus.pc_IDEX              <= '0;
         bus.pc_4_IDEX            <= '0;
         bus.rs2_data_IDEX        <= '0;
         bus.jump_branch_sel_IDEX <= 1'b0;
         bus.mem_wr_en_IDEX       <= 1'b0;
         bus.reg_wr_en_IDEX       <= 1'b0;
         bus.reg_wr_ctrl_IDEX     <= '0;
         bus.rd_IDEX              <= '0;
         bus.rs1_IDEX             <= '0;
         bus.rs2_IDEX             <= '0;
         bus.rs1_used_IDEX        <= 1'b0;
         bus.rs2_used_IDEX        <= 1'b0;
      end else begin
         bus.valid_IDEX           <= 1'b1;
         bus.op_IDEX              <= opcode;
         bus.funct7_IDEX          <= instr[31:25];
         bus.funct3_IDEX          <= instr[14:12];
         bus.in1_IDEX             <= pc_rs1_sel ? bus.pc_IFID : rs1_data;
         bus.in2_IDEX             <= imm_rs2_sel ? imm : rs2_data;
         bus.immediate_IDEX       <= imm;
         bus.pc_IDEX              <= bus.pc_IFID;
         bus.pc_4_IDEX            <= bus.pc_4_IFID;
         bus.rs2_data_IDEX        <= rs2_data;
         bus.jump_branch_sel_IDEX <= is_jb;
         bus.mem_wr_en_IDEX       <= is_store;
         bus.reg_wr_en_IDEX       <= writes_rd;
         bus.reg_wr_ctrl_IDEX     <= wr_ctrl;
         bus.rd_IDEX              <= rd_idx;
         bus.rs1_IDEX             <= rs1_idx;
         bus.rs2_IDEX             <= rs2_idx;
         bus.rs1_used_IDEX        <= rs1_used;
         bus.rs2_used_IDEX        <= rs2_used;
      end
   end

   // saturating count of interlock stall cycles; a flush cancels the stall
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (hazard && !bus.flush && stall_cnt_q != '1) begin
         stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
   end
endmodule
